// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Memory-mapped UART transmitter with a transmit FIFO, a programmable baud
// divisor, a status register, 1 or 2 stop bits and an optional interrupt.
//
// Parameters
//   DEPTH      FIFO entries (power of two, 2..64)
//   DIV_W      baud divisor width (8..16)
//   DIV_RESET  divisor after reset; one bit lasts DIV+1 clocks
//   STOP_BITS  stop bits per frame (1 or 2)
//
// Ports
//   i_clk       bus clock
//   i_reset_n   asynchronous active-low reset
//   i_addr      register select: 0 FIFO/status, 1 div low, 2 div high, 3 control
//   i_data_in   write data from the CPU bus
//   o_data_out  read data (0x00 unless i_r_n is low)
//   i_r_n       read strobe, active-low, no side effects
//   i_w_n       write strobe, active-low, one commit per low pulse
//   o_txd       serial output, idle high
//   o_irq_n     interrupt request, active-low
//
// Build option
//   UART_TX_IRQ_EN  when defined, control bit1 (IRQEN) and the IRQ output are
//                   present; otherwise o_irq_n is tied high and IRQEN reads 0.
module uart_tx_fifo #(
  parameter int DEPTH     = 16,
  parameter int DIV_W     = 16,
  parameter int DIV_RESET = 103,
  parameter int STOP_BITS = 1
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [1:0] i_addr,
  input  logic [7:0] i_data_in,
  output logic [7:0] o_data_out,
  input  logic       i_r_n,
  input  logic       i_w_n,
  output logic       o_txd,
  output logic       o_irq_n
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  // Bus interface and FIFO state
  logic             r_w_prev;
  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic [DIV_W-1:0] r_div;
  logic             r_txen;

  // Shifter state
  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit;
  logic             r_txd;

  logic             w_wr;
  logic             w_full;
  logic             w_empty;
  logic             w_idle;
  logic             w_push_req;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;
  logic             w_ovf_clr;
  logic             w_bit_end;
  logic             w_txd_nxt;
  logic             w_irqen;
  logic [15:0]      w_div16;

  // A write commits on the first edge that samples W low after sampling it high.
  assign w_wr       = r_w_prev & ~i_w_n;
  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_idle     = w_empty && (r_state == S_IDLE);
  assign w_push_req = w_wr && (i_addr == 2'd0);
  assign w_push     = w_push_req && !w_full;
  assign w_pop      = (r_state == S_IDLE) && r_txen && !w_empty;
  assign w_flush    = w_wr && (i_addr == 2'd3) && i_data_in[7];
  assign w_ovf_clr  = w_wr && (i_addr == 2'd3) && i_data_in[6];
  assign w_bit_end  = (r_cnt == '0);
  assign w_div16    = 16'(r_div);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_w_prev <= 1'b1;
    end else begin
      r_w_prev <= i_w_n;
    end
  end

  // FIFO storage is not reset; the pointers and count define its contents.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data_in;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      // Flush never coincides with a push (different address), and a pop on
      // the flush edge has already handed its byte to the shifter.
      if (w_flush) begin
        r_rd_ptr <= r_wr_ptr;
        r_count  <= '0;
      end else begin
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
      // Overflow is judged on the count before the edge, even if a pop
      // frees a slot on the same edge.
      if (w_push_req && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Divisor and control registers
`ifdef UART_TX_IRQ_EN
  logic r_irqen;
  assign w_irqen = r_irqen;
`else
  assign w_irqen = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_div  <= DIV_W'(DIV_RESET);
      r_txen <= 1'b1;
`ifdef UART_TX_IRQ_EN
      r_irqen <= 1'b0;
`endif
    end else if (w_wr) begin
      case (i_addr)
        2'd1: r_div <= DIV_W'({w_div16[15:8], i_data_in});
        2'd2: r_div <= DIV_W'({i_data_in, w_div16[7:0]});
        2'd3: begin
          r_txen <= i_data_in[0];
`ifdef UART_TX_IRQ_EN
          r_irqen <= i_data_in[1];
`endif
        end
        default: ;
      endcase
    end
  end

  // The line is driven from a register one clock behind the FSM, which gives
  // the push -> pop -> falling-edge latency and the one-clock gap between
  // back-to-back frames; every bit still lasts DIV+1 clocks.
  always_comb begin
    w_txd_nxt = 1'b1;
    case (r_state)
      S_START: w_txd_nxt = 1'b0;
      S_DATA:  w_txd_nxt = r_shift[0];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_bit   <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_txd <= w_txd_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_cnt   <= r_div;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= r_div;
            r_bit   <= '0;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt   <= r_div;
            r_shift <= r_shift >> 1;
            if (r_bit == 3'd7) begin
              r_bit   <= '0;
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end
        default: begin
          if (w_bit_end) begin
            if (r_bit == LAST_STOP) begin
              r_bit   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_bit <= r_bit + 3'd1;
              r_cnt <= r_div;
            end
          end else begin
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end
      endcase
    end
  end

  assign o_txd = r_txd;

`ifdef UART_TX_IRQ_EN
  assign o_irq_n = ~(r_irqen & w_empty);
`else
  assign o_irq_n = 1'b1;
`endif

  // Read mux: combinational while R is low
  always_comb begin
    o_data_out = 8'h00;
    if (!i_r_n) begin
      case (i_addr)
        2'd0:    o_data_out = {4'b0000, r_ovf, w_idle, w_empty, w_full};
        2'd1:    o_data_out = w_div16[7:0];
        2'd2:    o_data_out = w_div16[15:8];
        default: o_data_out = {6'b000000, w_irqen, r_txen};
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. Two instances share the bus: dut (defaults,
// 1 stop bit, DEPTH 16, 16-bit divisor) and dut2 (2 stop bits, DEPTH 4,
// 8-bit divisor). Expected line waveforms are built from the frame format:
// start 0, eight data bits LSB first, stop bits 1, each bit DIV+1 clocks.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic [1:0] addr;
  logic [7:0] din;
  logic       r_n;
  logic       w_n;
  logic       w2_n;
  logic [7:0] dout;
  logic [7:0] dout2;
  logic       txd;
  logic       txd2;
  logic       irq;
  logic       irq2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_wr = -10;
  int exp_dur [11];

`ifdef UART_TX_IRQ_EN
  localparam logic       IRQ_LOW = 1'b0;
  localparam logic [7:0] CTRL_IE = 8'h03;
`else
  localparam logic       IRQ_LOW = 1'b1;
  localparam logic [7:0] CTRL_IE = 8'h01;
`endif

  uart_tx_fifo dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_addr(addr), .i_data_in(din),
    .o_data_out(dout), .i_r_n(r_n), .i_w_n(w_n), .o_txd(txd), .o_irq_n(irq)
  );

  uart_tx_fifo #(.DEPTH(4), .DIV_W(8), .DIV_RESET(103), .STOP_BITS(2)) dut2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_addr(addr), .i_data_in(din),
    .o_data_out(dout2), .i_r_n(r_n), .i_w_n(w2_n), .o_txd(txd2), .o_irq_n(irq2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic logic txd_of(input int u);
    return (u == 0) ? txd : txd2;
  endfunction

  // Called just after a clock edge; returns just after the commit edge.
  task automatic cpu_write(input int u, input logic [1:0] a, input logic [7:0] d);
    if (cyc == last_wr) begin
      @(posedge clk);
      #1;
    end
    addr = a;
    din  = d;
    if (u == 0) w_n = 1'b0;
    else        w2_n = 1'b0;
    @(posedge clk);
    #1;
    w_n  = 1'b1;
    w2_n = 1'b1;
    last_wr = cyc;
  endtask

  task automatic cpu_read(input int u, input logic [1:0] a, output logic [7:0] d);
    addr = a;
    r_n  = 1'b0;
    #1;
    d = (u == 0) ? dout : dout2;
    r_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_dur(input int d);
    for (int i = 0; i < 11; i++) exp_dur[i] = d;
  endtask

  // Checks 'lead' idle-high clocks, then one frame of byte b, one comparison
  // per bit. Starts just after an edge, ends just after the final bit's edge.
  task automatic check_frame(input int u, input logic [7:0] b, input int lead, input string nm);
    int   nb;
    logic e;
    logic bad;
    logic got;
    nb = (u == 0) ? 10 : 11;
    for (int k = 0; k < lead; k++) begin
      @(negedge clk);
      n_cmp++;
      if (txd_of(u) !== 1'b1) begin
        n_err++;
        $display("FAIL %s idle-before-start clk %0d: txd=%b expected 1", nm, k, txd_of(u));
      end
      @(posedge clk);
    end
    for (int i = 0; i < nb; i++) begin
      if (i == 0)      e = 1'b0;
      else if (i <= 8) e = 1'(({24'd0, b} >> (i - 1)) & 32'd1);
      else             e = 1'b1;
      bad = 1'b0;
      got = e;
      for (int c = 0; c < exp_dur[i]; c++) begin
        @(negedge clk);
        if (txd_of(u) !== e && !bad) begin
          bad = 1'b1;
          got = txd_of(u);
        end
        @(posedge clk);
      end
      n_cmp++;
      if (bad) begin
        n_err++;
        $display("FAIL %s byte %02h bit %0d: txd=%b expected %b", nm, b, i, got, e);
      end
    end
    #1;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    rst_n = 1'b0;
    w_n = 1'b1; w2_n = 1'b1; r_n = 1'b1; addr = 2'd0; din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (txd !== 1'b1 || txd2 !== 1'b1) begin
      n_err++; $display("FAIL reset_txd: txd=%b txd2=%b expected 1 1", txd, txd2);
    end
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL reset_irq: irq=%b expected 1", irq);
    end
    n_cmp++;
    if (dout !== 8'h00) begin
      n_err++; $display("FAIL reset_dout_idle: dout=%02h expected 00", dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cpu_read(0, 2'd0, v);
    n_cmp++;
    if (v !== 8'h06) begin n_err++; $display("FAIL reset_status: got %02h expected 06", v); end
    cpu_read(0, 2'd3, v);
    n_cmp++;
    if (v !== 8'h01) begin n_err++; $display("FAIL reset_ctrl: got %02h expected 01", v); end
    cpu_read(0, 2'd1, v);
    n_cmp++;
    if (v !== 8'd103) begin n_err++; $display("FAIL reset_div_lo: got %02h expected 67", v); end
    cpu_read(0, 2'd2, v);
    n_cmp++;
    if (v !== 8'h00) begin n_err++; $display("FAIL reset_div_hi: got %02h expected 00", v); end
    cpu_read(1, 2'd0, v);
    n_cmp++;
    if (v !== 8'h06) begin n_err++; $display("FAIL reset_status2: got %02h expected 06", v); end
    n_cmp++;
    if (dout !== 8'h00) begin
      n_err++; $display("FAIL dout_after_read: dout=%02h expected 00", dout);
    end
  endtask

  task automatic test_basic;
    logic [7:0] v;
    cpu_write(0, 2'd2, 8'h01);
    cpu_read(0, 2'd2, v);
    n_cmp++;
    if (v !== 8'h01) begin n_err++; $display("FAIL div_hi_rw: got %02h expected 01", v); end
    cpu_write(0, 2'd2, 8'h00);
    cpu_write(0, 2'd1, 8'd3);
    set_dur(4);
    cpu_write(0, 2'd0, 8'h55);
    check_frame(0, 8'h55, 2, "basic");
    cpu_read(0, 2'd0, v);
    n_cmp++;
    if (v !== 8'h06) begin n_err++; $display("FAIL basic_status: got %02h expected 06", v); end
  endtask

  task automatic test_random_frames;
    logic [7:0] b;
    logic [7:0] v;
    int d;
    for (int it = 0; it < 6; it++) begin
      d = $urandom_range(0, 4);
      b = 8'($urandom_range(0, 255));
      cpu_write(0, 2'd1, 8'(d));
      cpu_read(0, 2'd1, v);
      n_cmp++;
      if (v !== 8'(d)) begin n_err++; $display("FAIL rand_div_rb: got %02h expected %02h", v, 8'(d)); end
      set_dur(d + 1);
      cpu_write(0, 2'd0, b);
      check_frame(0, b, 2, "rand");
    end
  endtask

  task automatic test_div_change;
    logic [7:0] b;
    logic [7:0] v;
    b = 8'($urandom_range(0, 255));
    cpu_write(0, 2'd1, 8'd3);
    for (int i = 0; i < 11; i++) exp_dur[i] = (i < 4) ? 4 : 8;
    cpu_write(0, 2'd0, b);
    fork
      check_frame(0, b, 2, "divchg");
      begin
        repeat (14) @(posedge clk);
        #1;
        cpu_write(0, 2'd1, 8'd7);
      end
    join
    cpu_read(0, 2'd1, v);
    n_cmp++;
    if (v !== 8'd7) begin n_err++; $display("FAIL divchg_rb: got %02h expected 07", v); end
  endtask

  task automatic test_two_stop;
    logic [7:0] v;
    cpu_write(1, 2'd2, 8'hFF);
    cpu_read(1, 2'd2, v);
    n_cmp++;
    if (v !== 8'h00) begin n_err++; $display("FAIL div8_hi: got %02h expected 00", v); end
    cpu_write(1, 2'd1, 8'd0);
    set_dur(1);
    cpu_write(1, 2'd0, 8'hA5);
    fork
      begin
        check_frame(1, 8'hA5, 2, "stop2_a");
        check_frame(1, 8'h3C, 1, "stop2_b");
      end
      cpu_write(1, 2'd0, 8'h3C);
    join
    cpu_read(1, 2'd0, v);
    n_cmp++;
    if (v !== 8'h06) begin n_err++; $display("FAIL stop2_status: got %02h expected 06", v); end
  endtask

  task automatic test_overflow;
    logic [7:0] q[$];
    logic [7:0] b;
    logic [7:0] v;
    cpu_write(0, 2'd1, 8'd1);
    cpu_write(0, 2'd3, 8'h00);
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom_range(0, 255));
      if (q.size() < 16) q.push_back(b);
      cpu_write(0, 2'd0, b);
    end
    cpu_read(0, 2'd0, v);
    n_cmp++;
    if (v !== 8'h09) begin n_err++; $display("FAIL ovf_status: got %02h expected 09", v); end
    cpu_write(0, 2'd3, 8'h40);
    cpu_read(0, 2'd0, v);
    n_cmp++;
    if (v !== 8'h01) begin n_err++; $display("FAIL ovf_clear: got %02h expected 01", v); end
    set_dur(2);
    cpu_write(0, 2'd3, 8'h01);
    for (int i = 0; i < 16; i++) begin
      check_frame(0, q[i], (i == 0) ? 2 : 1, "ovf_drain");
    end
    cpu_read(0, 2'd0, v);
    n_cmp++;
    if (v !== 8'h06) begin n_err++; $display("FAIL ovf_after: got %02h expected 06", v); end
  endtask

  task automatic test_flush;
    logic [7:0] a;
    logic [7:0] v;
    logic bad;
    a = 8'($urandom_range(0, 255));
    cpu_write(0, 2'd1, 8'd1);
    set_dur(2);
    cpu_write(0, 2'd0, a);
    fork
      check_frame(0, a, 2, "flush_a");
      begin
        cpu_write(0, 2'd0, 8'h00);
        repeat (4) @(posedge clk);
        #1;
        cpu_write(0, 2'd3, 8'h81);
      end
    join
    bad = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (txd !== 1'b1) bad = 1'b1;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bad) begin n_err++; $display("FAIL flush_line: txd went low=1 expected stays high"); end
    cpu_read(0, 2'd0, v);
    n_cmp++;
    if (v !== 8'h06) begin n_err++; $display("FAIL flush_status: got %02h expected 06", v); end
  endtask

  task automatic test_irq;
    logic [7:0] v;
    cpu_write(0, 2'd1, 8'd3);
    cpu_write(0, 2'd3, 8'h03);
    @(negedge clk);
    n_cmp++;
    if (irq !== IRQ_LOW) begin n_err++; $display("FAIL irq_empty: irq=%b expected %b", irq, IRQ_LOW); end
    @(posedge clk);
    #1;
    cpu_write(0, 2'd0, 8'h81);
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_after_push: irq=%b expected 1", irq); end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (irq !== IRQ_LOW) begin n_err++; $display("FAIL irq_after_pop: irq=%b expected %b", irq, IRQ_LOW); end
    @(posedge clk);
    #1;
    cpu_read(0, 2'd3, v);
    n_cmp++;
    if (v !== CTRL_IE) begin n_err++; $display("FAIL irq_ctrl: got %02h expected %02h", v, CTRL_IE); end
    repeat (50) @(posedge clk);
    #1;
    cpu_write(0, 2'd3, 8'h01);
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_disabled: irq=%b expected 1", irq); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    logic [7:0] v;
    logic bad;
    cpu_write(0, 2'd1, 8'd3);
    cpu_write(0, 2'd0, 8'h00);
    cpu_write(0, 2'd0, 8'h00);
    repeat (8) @(posedge clk);
    #3;
    n_cmp++;
    if (txd !== 1'b0) begin n_err++; $display("FAIL midframe_low: txd=%b expected 0", txd); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (txd !== 1'b1) begin n_err++; $display("FAIL async_reset_txd: txd=%b expected 1", txd); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cpu_read(0, 2'd0, v);
    n_cmp++;
    if (v !== 8'h06) begin n_err++; $display("FAIL rst_mid_status: got %02h expected 06", v); end
    cpu_read(0, 2'd1, v);
    n_cmp++;
    if (v !== 8'd103) begin n_err++; $display("FAIL rst_mid_div: got %02h expected 67", v); end
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (txd !== 1'b1) bad = 1'b1;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bad) begin n_err++; $display("FAIL rst_mid_line: txd went low=1 expected stays high"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_frames();
    test_div_change();
    test_two_stop();
    test_overflow();
    test_flush();
    test_irq();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
